// File: rtl/packet_pkg.sv
// Shared constants, state type and byte-enable helper for the payload packer.
package packet_pkg;

  localparam int HDR_A_W        = 48;
  localparam int HDR_B_W        = 48;
  localparam int HDR_C_W        = 16;
  localparam int HDR_BYTES      = 14;
  localparam int RESIDUAL_BYTES = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HDR1  = 2'd1,
    BODY  = 2'd2,
    FLUSH = 2'd3
  } packer_state_e;

  // MSB-contiguous mask with n bytes set, n in 0..8
  function automatic logic [7:0] be_from_count(input logic [3:0] n);
    logic [7:0] m;
    m = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(n)) begin
        m[7-i] = 1'b1;
      end else begin
        m[7-i] = 1'b0;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/payload_packer.sv
// Serialises headers A/B/C plus a 64-bit payload stream onto the packet bus.
// Optional packet counter enabled by defining PACKER_STATS_EN.
module payload_packer
  import packet_pkg::*;
#(
  parameter int COUNT_W = 32
) (
  input  logic               iClk,
  input  logic               iReset,
  input  logic               iHeader_valid,
  output logic               oHeader_ready,
  input  logic [HDR_A_W-1:0] iHeader_A,
  input  logic [HDR_B_W-1:0] iHeader_B,
  input  logic [HDR_C_W-1:0] iHeader_C,
  input  logic               iPayload_valid,
  output logic               oPayload_ready,
  input  logic [63:0]        iPayload,
  input  logic [7:0]         iPayload_byte_enable,
  input  logic               iPayload_last,
  output logic               oValid,
  input  logic               iReady,
  output logic [63:0]        oPacket,
  output logic               oSop,
  output logic               oEop,
  output logic [7:0]         oByte_enable,
  output logic [COUNT_W-1:0] oPacket_count
);

  localparam int RES_W = RESIDUAL_BYTES * 8;

  packer_state_e     r_state;
  logic [RES_W-1:0]  r_hdr_tail;
  logic [RES_W-1:0]  r_residual;
  logic [3:0]        r_last_n;

  logic              w_adv;
  logic              w_hdr_acc;
  logic              w_pay_acc;
  logic [3:0]        w_n;
  logic [63:0]       w_be_mask;
  logic [63:0]       w_pay_m;
  logic [RES_W-1:0]  w_front;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'd0, v[i]};
    end
    return c;
  endfunction

  // Ready is also held low while reset is asserted
  assign w_adv          = !oValid || iReady;
  assign oHeader_ready  = iReset && (r_state == IDLE) && w_adv;
  assign oPayload_ready = iReset && ((r_state == HDR1) || (r_state == BODY)) && w_adv;
  assign w_hdr_acc      = oHeader_ready && iHeader_valid;
  assign w_pay_acc      = oPayload_ready && iPayload_valid;
  assign w_n            = popcount8(iPayload_byte_enable);

  // Byte mask so bytes outside byte_enable never reach the bus
  always_comb begin
    w_be_mask = 64'd0;
    for (int i = 0; i < 8; i++) begin
      w_be_mask[i*8 +: 8] = {8{iPayload_byte_enable[i]}};
    end
    w_pay_m = iPayload & w_be_mask;
    if (r_state == HDR1) begin
      w_front = r_hdr_tail;
    end else begin
      w_front = r_residual;
    end
  end

  // Packing FSM and output register
  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      r_state      <= IDLE;
      r_hdr_tail   <= '0;
      r_residual   <= '0;
      r_last_n     <= 4'd0;
      oValid       <= 1'b0;
      oSop         <= 1'b0;
      oEop         <= 1'b0;
      oPacket      <= 64'd0;
      oByte_enable <= 8'h00;
    end else if (w_adv) begin
      case (r_state)
        IDLE: begin
          if (w_hdr_acc) begin
            oPacket      <= {iHeader_A, iHeader_B[47:32]};
            oByte_enable <= 8'hFF;
            oValid       <= 1'b1;
            oSop         <= 1'b1;
            oEop         <= 1'b0;
            r_hdr_tail   <= {iHeader_B[31:0], iHeader_C};
            r_state      <= HDR1;
          end else begin
            oPacket      <= 64'd0;
            oByte_enable <= 8'h00;
            oValid       <= 1'b0;
            oSop         <= 1'b0;
            oEop         <= 1'b0;
          end
        end
        HDR1, BODY: begin
          if (w_pay_acc) begin
            oPacket    <= {w_front, w_pay_m[63:48]};
            r_residual <= w_pay_m[47:0];
            r_last_n   <= w_n;
            oValid     <= 1'b1;
            oSop       <= 1'b0;
            if (iPayload_last && (w_n <= 4'd2)) begin
              oByte_enable <= be_from_count(4'd6 + w_n);
              oEop         <= 1'b1;
              r_state      <= IDLE;
            end else if (iPayload_last) begin
              oByte_enable <= 8'hFF;
              oEop         <= 1'b0;
              r_state      <= FLUSH;
            end else begin
              oByte_enable <= 8'hFF;
              oEop         <= 1'b0;
              r_state      <= BODY;
            end
          end else begin
            oPacket      <= 64'd0;
            oByte_enable <= 8'h00;
            oValid       <= 1'b0;
            oSop         <= 1'b0;
            oEop         <= 1'b0;
          end
        end
        FLUSH: begin
          oPacket      <= {r_residual, 16'h0000};
          oByte_enable <= be_from_count(r_last_n - 4'd2);
          oValid       <= 1'b1;
          oSop         <= 1'b0;
          oEop         <= 1'b1;
          r_state      <= IDLE;
        end
        default: begin
          oValid  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end else begin
      oValid <= oValid;
    end
  end

`ifdef PACKER_STATS_EN
  logic [COUNT_W-1:0] r_count;

  // Completed-packet counter, wraps naturally
  always_ff @(posedge iClk or negedge iReset) begin
    if (!iReset) begin
      r_count <= '0;
    end else if (oValid && iReady && oEop) begin
      r_count <= r_count + COUNT_W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign oPacket_count = r_count;
`else
  assign oPacket_count = '0;
`endif

endmodule

// File: tb/tb_payload_packer.sv
// Randomised bench for payload_packer: byte-stream reference model plus
// literal expectations for the documented example packets.
module tb_payload_packer;

  logic        iClk = 1'b0;
  logic        iReset = 1'b0;
  logic        iHeader_valid = 1'b0;
  logic        oHeader_ready;
  logic [47:0] iHeader_A = 48'd0;
  logic [47:0] iHeader_B = 48'd0;
  logic [15:0] iHeader_C = 16'd0;
  logic        iPayload_valid = 1'b0;
  logic        oPayload_ready;
  logic [63:0] iPayload = 64'd0;
  logic [7:0]  iPayload_byte_enable = 8'h00;
  logic        iPayload_last = 1'b0;
  logic        oValid;
  logic        iReady = 1'b1;
  logic [63:0] oPacket;
  logic        oSop;
  logic        oEop;
  logic [7:0]  oByte_enable;
  logic [31:0] oPacket_count;

  payload_packer #(.COUNT_W(32)) dut (
    .iClk(iClk), .iReset(iReset),
    .iHeader_valid(iHeader_valid), .oHeader_ready(oHeader_ready),
    .iHeader_A(iHeader_A), .iHeader_B(iHeader_B), .iHeader_C(iHeader_C),
    .iPayload_valid(iPayload_valid), .oPayload_ready(oPayload_ready),
    .iPayload(iPayload), .iPayload_byte_enable(iPayload_byte_enable),
    .iPayload_last(iPayload_last),
    .oValid(oValid), .iReady(iReady), .oPacket(oPacket), .oSop(oSop),
    .oEop(oEop), .oByte_enable(oByte_enable), .oPacket_count(oPacket_count)
  );

  always #5 iClk = ~iClk;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  be;
    logic        sop;
    logic        eop;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] pbytes[$];
  int checks = 0;
  int failures = 0;
  int eop_cnt = 0;
  int rdy_mode = 0;
  int rdy_ph = 0;
  bit chk_en = 1'b1;
  bit prev_stall = 1'b0;
  logic [74:0] prev_out;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Reference: the whole packet is just a byte string chopped into 8-byte beats
  task automatic build_expected(input logic [47:0] a, input logic [47:0] b, input logic [15:0] c);
    logic [7:0] s[$];
    beat_t bt;
    int nbeats;
    for (int i = 0; i < 6; i++) s.push_back(a[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) s.push_back(b[47-8*i -: 8]);
    s.push_back(c[15:8]);
    s.push_back(c[7:0]);
    foreach (pbytes[i]) s.push_back(pbytes[i]);
    nbeats = (s.size() + 7) / 8;
    for (int k = 0; k < nbeats; k++) begin
      bt = '0;
      for (int j = 0; j < 8; j++) begin
        if (8*k + j < s.size()) begin
          bt.d[63-8*j -: 8] = s[8*k+j];
          bt.be[7-j] = 1'b1;
        end
      end
      bt.sop = (k == 0);
      bt.eop = (k == nbeats - 1);
      exp_q.push_back(bt);
    end
  endtask

  task automatic drive_beat(input int k, input int nb);
    for (int j = 0; j < 8; j++) begin
      if (8*k + j < pbytes.size()) begin
        iPayload[63-8*j -: 8] = pbytes[8*k+j];
        iPayload_byte_enable[7-j] = 1'b1;
      end else begin
        iPayload[63-8*j -: 8] = 8'($urandom);
        iPayload_byte_enable[7-j] = 1'b0;
      end
    end
    iPayload_last = (k == nb - 1);
    iPayload_valid = 1'b1;
  endtask

  // Payload beat 0 is already offered while the header waits, and must be ignored in IDLE
  task automatic send_pkt(input logic [47:0] a, input logic [47:0] b, input logic [15:0] c,
                          input int abort_after);
    int nb, cyc, eop_before;
    logic acc;
    nb = (pbytes.size() + 7) / 8;
    if (abort_after < 0) build_expected(a, b, c);
    iHeader_A = a; iHeader_B = b; iHeader_C = c; iHeader_valid = 1'b1;
    drive_beat(0, nb);
    acc = 1'b0; cyc = 0;
    while (!acc && cyc < 200) begin
      @(negedge iClk); acc = oHeader_ready && iHeader_valid;
      @(posedge iClk); #1; cyc++;
    end
    if (!acc) chk("header_accept_timeout", 128'd0, 128'd1);
    iHeader_valid = 1'b0;
    chk("sop_latency", {126'd0, oValid, oSop}, 128'd3);
    for (int k = 0; k < nb; k++) begin
      if (k == abort_after) begin
        eop_before = eop_cnt;
        iReset = 1'b0;
        #2;
        chk("outputs_in_reset", {oValid, oSop, oEop, oHeader_ready, oPayload_ready, oPacket,
                                 oByte_enable, oPacket_count}, 128'd0);
        iPayload_valid = 1'b0;
        repeat (3) @(posedge iClk);
        chk("no_eop_aborted", 128'(eop_cnt), 128'(eop_before));
        @(negedge iClk); iReset = 1'b1;
        @(posedge iClk); #1;
        return;
      end
      if (k > 0 && $urandom_range(0, 3) == 0) begin
        iPayload_valid = 1'b0;
        @(posedge iClk); #1;
      end
      drive_beat(k, nb);
      acc = 1'b0; cyc = 0;
      while (!acc && cyc < 200) begin
        @(negedge iClk); acc = oPayload_ready && iPayload_valid;
        @(posedge iClk); #1; cyc++;
      end
      if (!acc) chk("payload_accept_timeout", 128'd0, 128'd1);
    end
    iPayload_valid = 1'b0;
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 1000) begin
      @(posedge iClk); cyc++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 128'(exp_q.size()), 128'd0);
    repeat (2) @(posedge iClk);
    #1;
  endtask

  task automatic pin(input string name, input int idx, input logic [63:0] d, input logic [7:0] be,
                     input logic sop, input logic eop);
    beat_t want;
    want = {d, be, sop, eop};
    if (idx < exp_q.size()) chk(name, 128'(exp_q[idx]), 128'(want));
    else chk(name, 128'd0, 128'(want));
  endtask

  task automatic check_count(input string name, input int want);
`ifdef PACKER_STATS_EN
    chk(name, 128'(oPacket_count), 128'(want));
`else
    chk(name, 128'(oPacket_count), 128'd0);
`endif
  endtask

  task automatic load_case(input int which);
    pbytes.delete();
    if (which == 1) begin
      pbytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    end else if (which == 2) begin
      pbytes.push_back(8'hAA);
    end else begin
      for (int i = 0; i < 16; i++) pbytes.push_back(8'(i));
    end
  endtask

  // iReady pattern: 0 = always, 1 = random, 2 = 1,0,0 repeating
  always @(posedge iClk) begin
    #1;
    case (rdy_mode)
      0: iReady = 1'b1;
      1: iReady = ($urandom_range(0, 3) != 0);
      default: begin
        iReady = (rdy_ph % 3 == 0);
        rdy_ph++;
      end
    endcase
  end

  // Single compare process: order/content, stall stability, ready exclusivity
  always @(negedge iClk) begin
    if (!iReset) begin
      prev_stall = 1'b0;
    end else begin
      if (oValid && iReady && oEop) eop_cnt++;
      if (chk_en) begin
        chk("ready_exclusive", {127'd0, oHeader_ready && oPayload_ready}, 128'd0);
        if (prev_stall)
          chk("stall_stable", 128'({oValid, oPacket, oByte_enable, oSop, oEop}), 128'(prev_out));
        if (oValid && iReady) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 128'({oPacket, oByte_enable, oSop, oEop}), 128'd0);
          end else begin
            chk("beat", 128'({oPacket, oByte_enable, oSop, oEop}), 128'(exp_q[0]));
            void'(exp_q.pop_front());
          end
        end
      end
      prev_stall = oValid && !iReady;
      prev_out = {oValid, oPacket, oByte_enable, oSop, oEop};
    end
  end

  initial begin
    logic [63:0] t1, t2;
    int base;
    #1;
    chk("reset_outputs", {oValid, oSop, oEop, oHeader_ready, oPayload_ready, oPacket,
                          oByte_enable, oPacket_count}, 128'd0);
    repeat (2) @(negedge iClk);
    iReset = 1'b1;
    @(posedge iClk); #1;

    // Documented examples back-to-back with model pinned to literals
    rdy_mode = 0;
    load_case(1);
    base = exp_q.size();
    build_expected(48'h010203040506, 48'h111213141516, 16'h2122);
    chk("pin1_count", 128'(exp_q.size() - base), 128'd3);
    pin("pin1_b0", base + 0, 64'h0102030405061112, 8'hFF, 1'b1, 1'b0);
    pin("pin1_b1", base + 1, 64'h131415162122AABB, 8'hFF, 1'b0, 1'b0);
    pin("pin1_b2", base + 2, 64'hCCDDEE0000000000, 8'hE0, 1'b0, 1'b1);
    repeat (3) void'(exp_q.pop_back());
    send_pkt(48'h010203040506, 48'h111213141516, 16'h2122, -1);

    load_case(2);
    base = exp_q.size();
    build_expected(48'h010203040506, 48'h111213141516, 16'h2122);
    chk("pin2_count", 128'(exp_q.size() - base), 128'd2);
    pin("pin2_b1", base + 1, 64'h131415162122AA00, 8'hFE, 1'b0, 1'b1);
    repeat (2) void'(exp_q.pop_back());
    send_pkt(48'h010203040506, 48'h111213141516, 16'h2122, -1);

    load_case(3);
    base = exp_q.size();
    build_expected(48'h010203040506, 48'h111213141516, 16'h2122);
    chk("pin3_count", 128'(exp_q.size() - base), 128'd4);
    pin("pin3_b2", base + 2, 64'h0203040506070809, 8'hFF, 1'b0, 1'b0);
    pin("pin3_b3", base + 3, 64'h0A0B0C0D0E0F0000, 8'hFC, 1'b0, 1'b1);
    repeat (4) void'(exp_q.pop_back());
    send_pkt(48'h010203040506, 48'h111213141516, 16'h2122, -1);
    drain();
    check_count("count_after_3", 3);

    // Same first packet under a 1,0,0 ready pattern
    rdy_mode = 2;
    load_case(1);
    send_pkt(48'h010203040506, 48'h111213141516, 16'h2122, -1);
    drain();

    // Reset in the middle of a 40-byte packet, then a clean 5-byte packet
    rdy_mode = 0;
    chk_en = 1'b0;
    pbytes.delete();
    for (int i = 0; i < 40; i++) pbytes.push_back(8'($urandom));
    send_pkt(48'hA0A1A2A3A4A5, 48'hB0B1B2B3B4B5, 16'hC0C1, 2);
    exp_q.delete();
    eop_cnt = 0;
    check_count("count_after_reset", 0);
    chk_en = 1'b1;
    load_case(1);
    send_pkt(48'h010203040506, 48'h111213141516, 16'h2122, -1);
    drain();
    check_count("count_after_abort", 1);

    // Randomised packets with random ready and input gaps
    rdy_mode = 1;
    for (int p = 0; p < 30; p++) begin
      pbytes.delete();
      for (int i = 0; i < int'($urandom_range(1, 40)); i++) pbytes.push_back(8'($urandom));
      t1 = {$urandom, $urandom};
      t2 = {$urandom, $urandom};
      send_pkt(t1[47:0], t2[47:0], t1[63:48], -1);
    end
    drain();
    check_count("count_final", eop_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/payload_packer.md
Name: payload_packer

Overview:
- Transmit-side counterpart of the packet dissector path.
- Takes header A (48b), header B (48b), header C (16b) and a beat-aligned 64-bit payload stream, and serialises them into the packet bus: 64-bit data, sop, eop, byte_enable.
- Headers occupy stream bytes 0..13, so payload byte 0 lands at stream byte 14. Payload is therefore re-aligned by a 6-byte residual register.
- Sits between the packet generator and the packet_intf sink.

Parameters:
COUNT_W, 32, width of the optional packet counter

Ports:
iClk  input  1  clock
iReset  input  1  asynchronous reset, active-low
iHeader_valid  input  1  header set valid
oHeader_ready  output  1  header set accepted this cycle
iHeader_A  input  48  header A
iHeader_B  input  48  header B
iHeader_C  input  16  header C
iPayload_valid  input  1  payload beat valid
oPayload_ready  output  1  payload beat accepted this cycle
iPayload  input  64  payload beat, byte 0 = bits [63:56]
iPayload_byte_enable  input  8  MSB-contiguous valid bytes; only the last beat may be partial
iPayload_last  input  1  final payload beat
oValid  output  1  output beat valid
iReady  input  1  downstream ready
oPacket  output  64  output beat, byte 0 = bits [63:56]
oSop  output  1  first beat of packet
oEop  output  1  last beat of packet
oByte_enable  output  8  valid bytes of output beat, MSB-contiguous
oPacket_count  output  COUNT_W  packets completed (PACKER_STATS_EN only)

Behaviour:
- Reset (iReset=0, asynchronous): state IDLE; oValid, oSop, oEop, oHeader_ready, oPayload_ready = 0; oPacket, oByte_enable = 0; residual = 0; oPacket_count = 0.
- Output register advance condition: adv = !oValid || iReady. The output holds stable while oValid && !iReady.
- Inputs are consumed only when ready && valid. Ready is combinational from state and adv.
- FSM:
  - IDLE: oHeader_ready = adv. On accept:
    - oPacket = {A[47:0], B[47:32]}, be FF, oSop = 1.
    - Capture B[31:0] and C.
    - → HDR1.
  - HDR1: oPayload_ready = adv. On accept of beat P (n valid bytes, 1..8):
    - oPacket = {B[31:0], C, P[63:48]}.
    - residual = P[47:0].
    - If last && n ≤ 2: be = first (6+n) bytes, oEop = 1, → IDLE.
    - If last && n > 2: be FF, → FLUSH.
    - Else: be FF, → BODY.
  - BODY: oPayload_ready = adv. On accept:
    - oPacket = {residual, P[63:48]}.
    - residual = P[47:0].
    - Same last/n rules as HDR1.
  - FLUSH: on adv:
    - oPacket = {residual, 16'h0}.
    - be = first (n−2) bytes of the latched last beat, oEop = 1.
    - → IDLE.
- If no input is accepted while adv = 1, oValid goes to 0.
- Latency: header accept → oSop beat visible on the next cycle. Every accepted input beat appears at the output one cycle later.
- Output beats per packet = 2 + ceil((L−2)/8) for payload length L ≥ 3; 2 for L ≤ 2.
- Zero-length payload is not supported; the payload stream carries at least one byte.
- Unused bytes (be = 0) are driven 0.
- oHeader_ready and oPayload_ready are never asserted together. A new header is not accepted until the IDLE following oEop, so back-to-back packets have no idle beat between them.
- iPayload_valid in IDLE is ignored (not consumed).
- Reset mid-packet: the packet is abandoned, no eop is emitted, and the first beat after reset release is a new sop.

Optional Feature:
- Macro: PACKER_STATS_EN.
- Defined: oPacket_count increments by 1 on each output beat with oEop accepted (oValid && iReady && oEop). Wraps at 2^COUNT_W. Cleared by reset.
- Undefined: the port is tied to 0 and no counter logic is generated.

Decomposition:
- packet_pkg gets:
  - HDR_A_W = 48, HDR_B_W = 48, HDR_C_W = 16
  - HDR_BYTES = 14, RESIDUAL_BYTES = 6
  - state typedef packer_state_e {IDLE, HDR1, BODY, FLUSH}
  - function be_from_count(n) → 8-bit MSB-contiguous mask
- No sub-module; the popcount of byte_enable is an inline function.

Test Plan:
- A=0x010203040506, B=0x111213141516, C=0x2122, payload AA BB CC DD EE (be F8, last), iReady=1 → beats:
  - 0x0102030405061112, sop, be FF
  - 0x1314151621 22AABB, be FF
  - 0xCCDDEE0000000000, be E0, eop
- Same headers, 1-byte payload 0xAA → beat0 as above; beat1 = 0x13141516 2122 AA00, be FE, eop; 2 beats total.
- 16-byte payload 00..0F (two full beats) → 4 beats; beat2 = 0x0203040506070809; beat3 = 0x0A0B0C0D0E0F0000, be FC, eop.
- Same as the first case with iReady toggling 1,0,0,1,… → identical beat sequence; oPacket, oByte_enable and flags stable while stalled; no input consumed during stall.
- iReset pulsed low during BODY of a 40-byte packet, then a 5-byte packet sent → no eop for the aborted packet; outputs 0 during reset; the new packet matches the first case exactly.
- PACKER_STATS_EN defined, 3 packets with iReady=1 → oPacket_count = 3. Undefined → oPacket_count stays 0.
